// File: rtl/mem_net_inject_arbiter_pkg.sv
// rtl/mem_net_inject_arbiter_pkg.sv - shared flit type, FSM states and sizing constants for the injection arbiter
package mem_net_inject_arbiter_pkg;

  localparam int FLIT_SIZE      = 64;
  localparam int WIDE_WIDTH     = 256;
  localparam int FLITS_PER_WIDE = WIDE_WIDTH / FLIT_SIZE;

  typedef struct packed {
    logic                 ipriority;
    logic                 last_flit;
    logic [FLIT_SIZE-1:0] payload;
  } generic_flit_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } inj_state_e;

endpackage

// File: rtl/mem_net_inject_arbiter_rr_arbiter.sv
// rtl/mem_net_inject_arbiter_rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic          found;
  int            idx;
  logic [IW-1:0] pos;

  // Scan the N positions starting at ptr, wrapping, and keep the first request seen
  always_comb begin
    onehot  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      pos = IW'(idx);
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        gnt_idx     = pos;
      end
    end
  end

endmodule

// File: rtl/mem_net_inject_arbiter.sv
// rtl/mem_net_inject_arbiter.sv - wormhole round-robin injection arbiter with credit flow control; MEM_NET_SRF_PRIORITY_EN enables priority-first arbitration
module mem_net_inject_arbiter
  import mem_net_inject_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUFFER_DEPTH = 4,
  parameter int MAX_FLITS    = FLITS_PER_WIDE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  generic_flit_t              req_flit [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output generic_flit_t              out_flit,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  input  logic                       credit_in,
  output logic                       credit_err,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int FW = $clog2(MAX_FLITS + 1);

  inj_state_e    state, state_n;
  logic [IW-1:0] grant_idx, grant_idx_n;
  logic [IW-1:0] rr_ptr, rr_ptr_n;
  logic [CW-1:0] credits, credits_n;
  logic [FW-1:0] flit_cnt, flit_cnt_n;
  logic          err_n;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      sel_idx;
  logic               accept;
  logic               credit_over;
  generic_flit_t      acc_flit;

`ifdef MEM_NET_SRF_PRIORITY_EN
  logic [NUM_REQ-1:0] pri_req, pri_oh, norm_oh;
  logic [IW-1:0]      pri_idx, norm_idx;

  // Requesters whose head flit is a wide SRF transfer form the priority set
  always_comb begin
    pri_req = '0;
    for (int i = 0; i < NUM_REQ; i++) pri_req[i] = req_valid[i] & req_flit[i].ipriority;
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb_pri (
    .req(pri_req), .ptr(rr_ptr), .onehot(pri_oh), .gnt_idx(pri_idx)
  );

  rr_arbiter #(.N(NUM_REQ)) u_arb_norm (
    .req(req_valid), .ptr(rr_ptr), .onehot(norm_oh), .gnt_idx(norm_idx)
  );

  assign win_onehot = (|pri_req) ? pri_oh  : norm_oh;
  assign win_idx    = (|pri_req) ? pri_idx : norm_idx;
`else
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .onehot(win_onehot), .gnt_idx(win_idx)
  );
`endif

  assign sel_idx     = (state == LOCKED) ? grant_idx : win_idx;
  assign accept      = |(req_valid & req_ready);
  assign acc_flit    = req_flit[sel_idx];
  assign credit_over = credit_in && (credits == CW'(BUFFER_DEPTH));
  assign busy        = (state == LOCKED);

  // Ready goes only to the locked owner or the fresh IDLE winner, and only with a credit in hand
  always_comb begin
    req_ready = '0;
    if (!rst && credits != '0) begin
      if (state == LOCKED) req_ready[grant_idx] = 1'b1;
      else                 req_ready = win_onehot;
    end
  end

  // Next-state: packet lock/unlock, pointer advance, credit accounting and sticky error
  always_comb begin
    state_n     = state;
    grant_idx_n = grant_idx;
    rr_ptr_n    = rr_ptr;
    flit_cnt_n  = flit_cnt;
    credits_n   = credits;
    err_n       = credit_err | credit_over |
                  (accept && !acc_flit.last_flit && flit_cnt == FW'(MAX_FLITS - 1));

    case ({accept, credit_in})
      2'b10:   credits_n = credits - CW'(1);
      2'b01:   credits_n = credit_over ? credits : credits + CW'(1);
      default: credits_n = credits;
    endcase

    if (accept) begin
      if (acc_flit.last_flit) begin
        state_n    = IDLE;
        rr_ptr_n   = (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + IW'(1);
        flit_cnt_n = '0;
      end else begin
        state_n     = LOCKED;
        grant_idx_n = sel_idx;
        flit_cnt_n  = (flit_cnt == FW'(MAX_FLITS)) ? flit_cnt : flit_cnt + FW'(1);
      end
    end
  end

  // State and output register; the accepted flit lands on the output one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_idx  <= '0;
      rr_ptr     <= '0;
      credits    <= CW'(BUFFER_DEPTH);
      flit_cnt   <= '0;
      credit_err <= 1'b0;
      out_valid  <= 1'b0;
      out_flit   <= '0;
      out_src    <= '0;
    end else begin
      state      <= state_n;
      grant_idx  <= grant_idx_n;
      rr_ptr     <= rr_ptr_n;
      credits    <= credits_n;
      flit_cnt   <= flit_cnt_n;
      credit_err <= err_n;
      out_valid  <= accept;
      if (accept) begin
        out_flit <= acc_flit;
        out_src  <= sel_idx;
      end
    end
  end

endmodule
